// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared system bus: one-hot grant with a turnaround gap,
// a grant-hold timeout, and a transaction watchdog that aborts stalled transfers.
module bus_arbiter #(
  parameter int NUM_MASTERS   = 4,
  parameter int GRANT_TIMEOUT = 16,
  parameter int BUS_TIMEOUT   = 256
) (
  input  logic                   system_clock,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] request,
  output logic [NUM_MASTERS-1:0] grant,
  input  logic                   begin_transactionIN,
  input  logic                   end_transactionIN,
  input  logic                   data_validIN,
  output logic                   errorOUT,
  output logic                   end_transactionOUT
);

  localparam int MAX_TO = (GRANT_TIMEOUT > BUS_TIMEOUT) ? GRANT_TIMEOUT : BUS_TIMEOUT;
  localparam int CNT_W  = $clog2(MAX_TO) + 1;
  localparam int IDX_W  = $clog2(NUM_MASTERS);

  localparam logic [CNT_W-1:0]       CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]       CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]       GRANT_LAST = CNT_W'(GRANT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]       BUS_LAST   = CNT_W'(BUS_TIMEOUT - 1);
  localparam logic [IDX_W-1:0]       IDX_ZERO   = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]       IDX_LAST   = IDX_W'(NUM_MASTERS - 1);
  localparam logic [NUM_MASTERS-1:0] GNT_NONE   = {NUM_MASTERS{1'b0}};
  localparam logic [NUM_MASTERS-1:0] GNT_ONE    = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_GRANTED = 2'b01,
    S_ACTIVE  = 2'b10,
    S_ABORT   = 2'b11
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [CNT_W-1:0]       counter_q, counter_d;
  logic [IDX_W-1:0]       last_owner_q, last_owner_d;
  logic                   error_q, error_d;
  logic                   end_out_q, end_out_d;

  logic [IDX_W-1:0]       cand_s;
  logic [IDX_W-1:0]       sel_idx_s;
  logic                   sel_found_s;
  logic                   sel_hit_s;
  logic [CNT_W-1:0]       counter_inc_s;

  // Round-robin pick: first requester strictly after the previous owner, wrapping.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = IDX_ZERO;
    sel_hit_s   = 1'b0;
    cand_s      = last_owner_q;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand_s      = (cand_s == IDX_LAST) ? IDX_ZERO : cand_s + IDX_W'(1);
      sel_hit_s   = !sel_found_s && request[cand_s];
      sel_idx_s   = sel_hit_s ? cand_s : sel_idx_s;
      sel_found_s = sel_found_s | sel_hit_s;
    end
  end

  assign counter_inc_s = (counter_q == CNT_MAX) ? counter_q : counter_q + CNT_W'(1);

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    counter_d    = counter_q;
    last_owner_d = last_owner_q;
    error_d      = 1'b0;
    end_out_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        counter_d = CNT_ZERO;
        if (sel_found_s) begin
          state_d      = S_GRANTED;
          grant_d      = GNT_ONE << sel_idx_s;
          last_owner_d = sel_idx_s;
        end else begin
          grant_d = GNT_NONE;
        end
      end
      S_GRANTED: begin
        if (begin_transactionIN) begin
          state_d   = S_ACTIVE;
          counter_d = CNT_ZERO;
        end else if (!request[last_owner_q] || (counter_q == GRANT_LAST)) begin
          state_d   = S_IDLE;
          grant_d   = GNT_NONE;
          counter_d = CNT_ZERO;
        end else begin
          counter_d = counter_inc_s;
        end
      end
      S_ACTIVE: begin
        // A clean end in the same cycle as watchdog expiry wins over the abort.
        if (end_transactionIN) begin
          state_d   = S_IDLE;
          grant_d   = GNT_NONE;
          counter_d = CNT_ZERO;
        end else if (counter_q == BUS_LAST) begin
          state_d   = S_ABORT;
          grant_d   = GNT_NONE;
          counter_d = CNT_ZERO;
          error_d   = 1'b1;
          end_out_d = 1'b1;
        end else if (data_validIN) begin
          counter_d = CNT_ZERO;
        end else begin
          counter_d = counter_inc_s;
        end
      end
      S_ABORT: begin
        state_d   = S_IDLE;
        grant_d   = GNT_NONE;
        counter_d = CNT_ZERO;
      end
      default: begin
        state_d   = S_IDLE;
        grant_d   = GNT_NONE;
        counter_d = CNT_ZERO;
      end
    endcase
  end

  // State, counter, owner history and registered outputs.
  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= GNT_NONE;
      counter_q    <= CNT_ZERO;
      last_owner_q <= IDX_LAST;
      error_q      <= 1'b0;
      end_out_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      counter_q    <= counter_d;
      last_owner_q <= last_owner_d;
      error_q      <= error_d;
      end_out_q    <= end_out_d;
    end
  end

  assign grant              = grant_q;
  assign errorOUT           = error_q;
  assign end_transactionOUT = end_out_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus random traffic, all checked
// against a cycle-level reference model of ownership and timeouts.
module tb_bus_arbiter;

  localparam int N  = 4;
  localparam int GT = 16;
  localparam int BT = 256;

  logic         clk  = 1'b0;
  logic         rst  = 1'b0;
  logic [N-1:0] req  = 4'b0000;
  logic         beg  = 1'b0;
  logic         endi = 1'b0;
  logic         dv   = 1'b0;
  logic [N-1:0] gnt;
  logic         err;
  logic         endo;

  int checks = 0;
  int errors = 0;

  // Reference model: owner index (-1 = bus free), transaction flag, age timer.
  int m_owner;
  int m_last;
  int m_age;
  bit m_txn;
  bit m_err;

  bus_arbiter #(.NUM_MASTERS(N), .GRANT_TIMEOUT(GT), .BUS_TIMEOUT(BT)) dut (
    .system_clock        (clk),
    .reset               (rst),
    .request             (req),
    .grant               (gnt),
    .begin_transactionIN (beg),
    .end_transactionIN   (endi),
    .data_validIN        (dv),
    .errorOUT            (err),
    .end_transactionOUT  (endo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] m_grant();
    logic [N-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_age   = 0;
    m_txn   = 1'b0;
    m_err   = 1'b0;
  endtask

  // One clock edge of the bus rules, applied to the inputs sampled at that edge.
  task automatic model_step();
    int  prev_owner;
    bit  prev_err;
    bit  found;
    int  c;
    prev_owner = m_owner;
    prev_err   = m_err;
    m_err      = 1'b0;
    if (prev_owner < 0) begin
      if (!prev_err) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (!found && req[c]) begin
            found   = 1'b1;
            m_owner = c;
            m_last  = c;
            m_age   = 0;
            m_txn   = 1'b0;
          end
        end
      end
    end else if (!m_txn) begin
      if (beg) begin
        m_txn = 1'b1;
        m_age = 0;
      end else if (!req[prev_owner] || m_age == GT - 1) begin
        m_owner = -1;
      end else begin
        m_age++;
      end
    end else begin
      if (endi) begin
        m_owner = -1;
      end else if (m_age == BT - 1) begin
        m_owner = -1;
        m_err   = 1'b1;
      end else if (dv) begin
        m_age = 0;
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("grant", gnt, m_grant());
    chk("errorOUT", err, m_err);
    chk("end_out", endo, m_err);
    chk("onehot", ($countones(gnt) <= 1), 1);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = 4'b0000;
    beg  = 1'b0;
    endi = 1'b0;
    dv   = 1'b0;
    model_reset();
    #1;
    chk("rst_grant", gnt, 0);
    chk("rst_err", err, 0);
    chk("rst_endo", endo, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] t1_exp [5];
    t1_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    #2;

    // 1: round-robin rotation with everyone requesting
    do_reset();
    req = 4'b1111;
    tick();
    chk("t1_first", gnt, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      chk("t1_grant", gnt, t1_exp[i]);
      beg = 1'b1; tick(); beg = 1'b0;
      endi = 1'b1; tick(); endi = 1'b0;
      chk("t1_gap", gnt, 0);
      tick();
    end

    // 2: single master, begin at cycle 2, end at cycle 10
    do_reset();
    req = 4'b0100;
    for (int c = 1; c <= 11; c++) begin
      tick();
      chk("t2_grant", gnt, (c <= 10) ? 4'b0100 : 4'b0000);
      chk("t2_err", err, 0);
      beg  = (c == 2);
      endi = (c == 10);
    end
    req = 4'b0000; beg = 1'b0; endi = 1'b0;
    tick(); tick();

    // 3: grant revoked after GT cycles without begin, one gap, re-grant
    do_reset();
    req = 4'b0010;
    for (int c = 1; c <= 18; c++) begin
      tick();
      chk("t3_grant", gnt, (c == 17) ? 4'b0000 : 4'b0010);
    end
    req = 4'b0000;
    tick(); tick();

    // 4: watchdog abort after BT silent cycles
    do_reset();
    req = 4'b0001;
    tick();
    beg = 1'b1; tick(); beg = 1'b0;
    for (int c = 3; c <= 257; c++) begin
      tick();
      chk("t4_hold", gnt, 4'b0001);
    end
    tick();
    chk("t4_abort_err", err, 1);
    chk("t4_abort_end", endo, 1);
    chk("t4_abort_gnt", gnt, 0);
    req = 4'b0000;
    tick();
    chk("t4_after_err", err, 0);
    chk("t4_after_gnt", gnt, 0);

    // 5: periodic data_valid keeps the transfer alive; end beats expiry
    do_reset();
    req = 4'b0100;
    tick();
    beg = 1'b1; tick(); beg = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      dv = (k % 200 == 199);
      tick();
      chk("t5_no_abort", err, 0);
    end
    dv = 1'b0;
    for (int k = 0; k < 300 && m_age != BT - 1; k++) tick();
    chk("t5_age_reached", m_age, BT - 1);
    endi = 1'b1;
    tick();
    endi = 1'b0;
    req  = 4'b0000;
    chk("t5_end_gnt", gnt, 0);
    chk("t5_end_err", err, 0);
    chk("t5_end_endo", endo, 0);
    tick();

    // 6: reset during an active transfer, then a fresh grant to master 3
    do_reset();
    req = 4'b0001;
    tick();
    beg = 1'b1; tick(); beg = 1'b0;
    chk("t6_pre", gnt, 4'b0001);
    do_reset();
    req = 4'b1000;
    tick();
    chk("t6_regrant", gnt, 4'b1000);
    req = 4'b0000;
    tick(); tick();

    // Random traffic, busy phase then a slow phase that lets the watchdog fire
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      req  = 4'($urandom_range(0, 15));
      beg  = ($urandom_range(0, 3) == 0);
      endi = ($urandom_range(0, 7) == 0);
      dv   = ($urandom_range(0, 3) == 0);
      tick();
    end
    for (int k = 0; k < 4000; k++) begin
      req  = 4'($urandom_range(1, 15));
      beg  = ($urandom_range(0, 2) == 0);
      endi = ($urandom_range(0, 999) == 0);
      dv   = ($urandom_range(0, 399) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
